// File: rtl/cpu_pkg.sv
// Shared opcode encodings, control-step states and strobe bundle for the single-bus CPU.
// Build option CU_MULDIV_EN enables the mul/div control sequence; otherwise those opcodes behave as nop.
package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_SHL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_DIV  = 5'b01111;
    localparam opcode_t OP_MUL  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_BR   = 5'b10011;
    localparam opcode_t OP_JR   = 5'b10101;
    localparam opcode_t OP_IN   = 5'b10110;
    localparam opcode_t OP_OUT  = 5'b10111;
    localparam opcode_t OP_MFLO = 5'b11000;
    localparam opcode_t OP_MFHI = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

`ifdef CU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        RST, PARK, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } cu_state_t;

    typedef struct packed {
        logic HIin;
        logic LOin;
        logic PCin;
        logic MDRin;
        logic Zin;
        logic Yin;
        logic MARin;
        logic IRin;
        logic CONin;
        logic OUTPORTin;
        logic HIout;
        logic LOout;
        logic ZHIout;
        logic ZLOout;
        logic PCout;
        logic MDRout;
        logic INPORTout;
        logic Yout;
        logic Cout;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
        logic BAout;
        logic Read;
        logic write;
        logic IncPC;
        logic Run;
    } cu_strobes_t;

    function automatic logic is_alu(opcode_t op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_imm(opcode_t op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    function automatic logic is_mem(opcode_t op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic is_muldiv(opcode_t op);
        return MULDIV_EN && ((op == OP_MUL) || (op == OP_DIV));
    endfunction

    // Final control step of each instruction class; anything unlisted ends after fetch.
    function automatic cu_state_t last_step(opcode_t op);
        if (op == OP_LD || op == OP_ST)                  return T7;
        if (op == OP_BR || is_muldiv(op))                return T6;
        if (is_alu(op) || is_imm(op) || op == OP_LDI)    return T5;
        if (op == OP_NEG || op == OP_NOT)                return T4;
        if (op == OP_JR || op == OP_IN || op == OP_OUT ||
            op == OP_MFHI || op == OP_MFLO)              return T3;
        return T2;
    endfunction

    function automatic cu_state_t next_step(cu_state_t s);
        case (s)
            T0:      return T1;
            T1:      return T2;
            T2:      return T3;
            T3:      return T4;
            T4:      return T5;
            T5:      return T6;
            T6:      return T7;
            default: return T0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface control_unit_if;
    logic [31:0] IR;
    logic CON, Stop;
    logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, OUTPORTout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, write, IncPC, Run;

    modport master (
        input  IR, CON, Stop,
        output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, OUTPORTout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, write, IncPC, Run
    );

    modport slave (
        output IR, CON, Stop,
        input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, OUTPORTout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, write, IncPC, Run
    );
endinterface

// File: rtl/cu_step_decode.sv
// Combinational strobe decode from (control step, opcode, CON) for the single-bus datapath.
module cu_step_decode
    import cpu_pkg::*;
(
    input  cu_state_t   state,
    input  opcode_t     op,
    input  logic        con,
    output cu_strobes_t strobes
);

    always_comb begin
        strobes     = '0;
        strobes.Run = !(state inside {RST, PARK, HALT});
        case (state)
            T0: begin strobes.PCout = 1'b1; strobes.MARin = 1'b1; end
            T1: begin
                strobes.Read = 1'b1; strobes.MDRin = 1'b1;
                strobes.PCin = 1'b1; strobes.IncPC = 1'b1;
            end
            T2: begin strobes.MDRout = 1'b1; strobes.IRin = 1'b1; end
            T3: begin
                if (is_mem(op)) begin
                    strobes.Grb = 1'b1; strobes.BAout = 1'b1; strobes.Yin = 1'b1;
                end else if (is_alu(op) || is_imm(op)) begin
                    strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.Yin = 1'b1;
                end else if (op == OP_NEG || op == OP_NOT) begin
                    strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.Zin = 1'b1;
                end else if (is_muldiv(op)) begin
                    strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.Yin = 1'b1;
                end else if (op == OP_BR) begin
                    strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.CONin = 1'b1;
                end else if (op == OP_JR) begin
                    strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.PCin = 1'b1;
                end else if (op == OP_IN) begin
                    strobes.INPORTout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end else if (op == OP_OUT) begin
                    strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.OUTPORTin = 1'b1;
                end else if (op == OP_MFHI) begin
                    strobes.HIout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end else if (op == OP_MFLO) begin
                    strobes.LOout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end
            end
            T4: begin
                if (is_mem(op) || is_imm(op)) begin
                    strobes.Cout = 1'b1; strobes.Zin = 1'b1;
                end else if (is_alu(op)) begin
                    strobes.Grc = 1'b1; strobes.Rout = 1'b1; strobes.Zin = 1'b1;
                end else if (op == OP_NEG || op == OP_NOT) begin
                    strobes.ZLOout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end else if (is_muldiv(op)) begin
                    strobes.Grb = 1'b1; strobes.Rout = 1'b1; strobes.Zin = 1'b1;
                end else if (op == OP_BR) begin
                    strobes.PCout = 1'b1; strobes.Yin = 1'b1;
                end
            end
            T5: begin
                if (is_alu(op) || is_imm(op) || op == OP_LDI) begin
                    strobes.ZLOout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end else if (op == OP_LD || op == OP_ST) begin
                    strobes.ZLOout = 1'b1; strobes.MARin = 1'b1;
                end else if (is_muldiv(op)) begin
                    strobes.ZLOout = 1'b1; strobes.LOin = 1'b1;
                end else if (op == OP_BR) begin
                    strobes.Cout = 1'b1; strobes.Zin = 1'b1;
                end
            end
            T6: begin
                if (op == OP_LD) begin
                    strobes.Read = 1'b1; strobes.MDRin = 1'b1;
                end else if (op == OP_ST) begin
                    strobes.Gra = 1'b1; strobes.Rout = 1'b1; strobes.MDRin = 1'b1;
                end else if (is_muldiv(op)) begin
                    strobes.ZHIout = 1'b1; strobes.HIin = 1'b1;
                end else if (op == OP_BR && con) begin
                    // Branch target already sits in Z; CON was latched at T3.
                    strobes.ZLOout = 1'b1; strobes.PCin = 1'b1;
                end
            end
            T7: begin
                if (op == OP_LD) begin
                    strobes.MDRout = 1'b1; strobes.Gra = 1'b1; strobes.Rin = 1'b1;
                end else if (op == OP_ST) begin
                    strobes.write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: step register, next-step sequencing and strobe fan-out.
// mul/div sequencing is present only when CU_MULDIV_EN is defined (see cpu_pkg).
module control_unit
    import cpu_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    control_unit_if.master  cu
);

    cu_state_t   state, state_nx;
    cu_strobes_t dec, st;
    opcode_t     op;
    logic        unused_ir;

    assign op        = cu.IR[31:27];
    assign unused_ir = ^cu.IR[26:0];

    always_ff @(posedge Clock) begin
        if (Reset) state <= RST;
        else       state <= state_nx;
    end

    // Stop is only honoured between instructions, never mid-sequence.
    always_comb begin
        state_nx = state;
        case (state)
            RST, PARK: state_nx = cu.Stop ? PARK : T0;
            HALT:      state_nx = HALT;
            default: begin
                if (state == T2 && op == OP_HALT)  state_nx = HALT;
                else if (state == last_step(op))   state_nx = cu.Stop ? PARK : T0;
                else                               state_nx = next_step(state);
            end
        endcase
    end

    cu_step_decode u_decode (
        .state   (state),
        .op      (op),
        .con     (cu.CON),
        .strobes (dec)
    );

    // Reset forces every output low in the same cycle, so an aborted store cannot write.
    assign st = Reset ? '0 : dec;

    assign cu.HIin       = st.HIin;
    assign cu.LOin       = st.LOin;
    assign cu.PCin       = st.PCin;
    assign cu.MDRin      = st.MDRin;
    assign cu.Zin        = st.Zin;
    assign cu.Yin        = st.Yin;
    assign cu.MARin      = st.MARin;
    assign cu.IRin       = st.IRin;
    assign cu.CONin      = st.CONin;
    assign cu.OUTPORTin  = st.OUTPORTin;
    assign cu.HIout      = st.HIout;
    assign cu.LOout      = st.LOout;
    assign cu.ZHIout     = st.ZHIout;
    assign cu.ZLOout     = st.ZLOout;
    assign cu.PCout      = st.PCout;
    assign cu.MDRout     = st.MDRout;
    assign cu.INPORTout  = st.INPORTout;
    assign cu.Yout       = st.Yout;
    assign cu.Cout       = st.Cout;
    assign cu.OUTPORTout = 1'b0;
    assign cu.Gra        = st.Gra;
    assign cu.Grb        = st.Grb;
    assign cu.Grc        = st.Grc;
    assign cu.Rin        = st.Rin;
    assign cu.Rout       = st.Rout;
    assign cu.BAout      = st.BAout;
    assign cu.Read       = st.Read;
    assign cu.write      = st.write;
    assign cu.IncPC      = st.IncPC;
    assign cu.Run        = st.Run;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobe sets from an instruction-level model.
module tb_control_unit;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    control_unit_if cu();

    control_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .cu    (cu)
    );

    localparam logic [31:0] M_RUN     = 32'd1 << 0;
    localparam logic [31:0] M_HIIN    = 32'd1 << 1;
    localparam logic [31:0] M_LOIN    = 32'd1 << 2;
    localparam logic [31:0] M_PCIN    = 32'd1 << 3;
    localparam logic [31:0] M_MDRIN   = 32'd1 << 4;
    localparam logic [31:0] M_ZIN     = 32'd1 << 5;
    localparam logic [31:0] M_YIN     = 32'd1 << 6;
    localparam logic [31:0] M_MARIN   = 32'd1 << 7;
    localparam logic [31:0] M_IRIN    = 32'd1 << 8;
    localparam logic [31:0] M_CONIN   = 32'd1 << 9;
    localparam logic [31:0] M_OPIN    = 32'd1 << 10;
    localparam logic [31:0] M_HIOUT   = 32'd1 << 11;
    localparam logic [31:0] M_LOOUT   = 32'd1 << 12;
    localparam logic [31:0] M_ZHIOUT  = 32'd1 << 13;
    localparam logic [31:0] M_ZLOOUT  = 32'd1 << 14;
    localparam logic [31:0] M_PCOUT   = 32'd1 << 15;
    localparam logic [31:0] M_MDROUT  = 32'd1 << 16;
    localparam logic [31:0] M_INPOUT  = 32'd1 << 17;
    localparam logic [31:0] M_YOUT    = 32'd1 << 18;
    localparam logic [31:0] M_COUT    = 32'd1 << 19;
    localparam logic [31:0] M_OPOUT   = 32'd1 << 20;
    localparam logic [31:0] M_GRA     = 32'd1 << 21;
    localparam logic [31:0] M_GRB     = 32'd1 << 22;
    localparam logic [31:0] M_GRC     = 32'd1 << 23;
    localparam logic [31:0] M_RIN     = 32'd1 << 24;
    localparam logic [31:0] M_ROUT    = 32'd1 << 25;
    localparam logic [31:0] M_BAOUT   = 32'd1 << 26;
    localparam logic [31:0] M_READ    = 32'd1 << 27;
    localparam logic [31:0] M_WRITE   = 32'd1 << 28;
    localparam logic [31:0] M_INCPC   = 32'd1 << 29;

    logic [31:0] obs_v;
    always_comb begin
        obs_v     = '0;
        obs_v[0]  = cu.Run;     obs_v[1]  = cu.HIin;    obs_v[2]  = cu.LOin;
        obs_v[3]  = cu.PCin;    obs_v[4]  = cu.MDRin;   obs_v[5]  = cu.Zin;
        obs_v[6]  = cu.Yin;     obs_v[7]  = cu.MARin;   obs_v[8]  = cu.IRin;
        obs_v[9]  = cu.CONin;   obs_v[10] = cu.OUTPORTin; obs_v[11] = cu.HIout;
        obs_v[12] = cu.LOout;   obs_v[13] = cu.ZHIout;  obs_v[14] = cu.ZLOout;
        obs_v[15] = cu.PCout;   obs_v[16] = cu.MDRout;  obs_v[17] = cu.INPORTout;
        obs_v[18] = cu.Yout;    obs_v[19] = cu.Cout;    obs_v[20] = cu.OUTPORTout;
        obs_v[21] = cu.Gra;     obs_v[22] = cu.Grb;     obs_v[23] = cu.Grc;
        obs_v[24] = cu.Rin;     obs_v[25] = cu.Rout;    obs_v[26] = cu.BAout;
        obs_v[27] = cu.Read;    obs_v[28] = cu.write;   obs_v[29] = cu.IncPC;
    end

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] seq_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Monitor: one expected output vector per cycle, sampled mid-cycle.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (obs_v !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, obs_v, e);
                end
            end
        end
    end

    task automatic cyc(input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge Clock);
        #1;
    endtask

    // Instruction-level reference: the list of strobe sets for each control step.
    task automatic build(input logic [4:0] op, input logic con);
        seq_q = {};
        seq_q.push_back(M_PCOUT | M_MARIN);
        seq_q.push_back(M_READ | M_MDRIN | M_PCIN | M_INCPC);
        seq_q.push_back(M_MDROUT | M_IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                seq_q.push_back(M_GRB | M_ROUT | M_YIN);
                seq_q.push_back(M_GRC | M_ROUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                seq_q.push_back(M_GRB | M_ROUT | M_YIN);
                seq_q.push_back(M_COUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b00001: begin
                seq_q.push_back(M_GRB | M_BAOUT | M_YIN);
                seq_q.push_back(M_COUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
            end
            5'b00000, 5'b00010: begin
                seq_q.push_back(M_GRB | M_BAOUT | M_YIN);
                seq_q.push_back(M_COUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_MARIN);
                if (op == 5'b00000) begin
                    seq_q.push_back(M_READ | M_MDRIN);
                    seq_q.push_back(M_MDROUT | M_GRA | M_RIN);
                end else begin
                    seq_q.push_back(M_GRA | M_ROUT | M_MDRIN);
                    seq_q.push_back(M_WRITE);
                end
            end
            5'b10001, 5'b10010: begin
                seq_q.push_back(M_GRB | M_ROUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_GRA | M_RIN);
            end
`ifdef CU_MULDIV_EN
            5'b01111, 5'b10000: begin
                seq_q.push_back(M_GRA | M_ROUT | M_YIN);
                seq_q.push_back(M_GRB | M_ROUT | M_ZIN);
                seq_q.push_back(M_ZLOOUT | M_LOIN);
                seq_q.push_back(M_ZHIOUT | M_HIIN);
            end
`endif
            5'b10011: begin
                seq_q.push_back(M_GRA | M_ROUT | M_CONIN);
                seq_q.push_back(M_PCOUT | M_YIN);
                seq_q.push_back(M_COUT | M_ZIN);
                seq_q.push_back(con ? (M_ZLOOUT | M_PCIN) : 32'd0);
            end
            5'b10101: seq_q.push_back(M_GRA | M_ROUT | M_PCIN);
            5'b10110: seq_q.push_back(M_INPOUT | M_GRA | M_RIN);
            5'b10111: seq_q.push_back(M_GRA | M_ROUT | M_OPIN);
            5'b11000: seq_q.push_back(M_LOOUT | M_GRA | M_RIN);
            5'b11001: seq_q.push_back(M_HIOUT | M_GRA | M_RIN);
            default: ;
        endcase
        foreach (seq_q[i]) seq_q[i] = seq_q[i] | M_RUN;
    endtask

    // Stop wiggles randomly on non-final steps; only its value on the final step may matter.
    task automatic run_instr(input logic [31:0] ir, input logic con, input bit stop_end,
                             input int unsigned stop_from, input int unsigned park);
        int unsigned n;
        build(ir[31:27], con);
        n = seq_q.size();
        cu.IR  = ir;
        cu.CON = con;
        for (int unsigned i = 0; i < n; i++) begin
            if (i == n - 1)                      cu.Stop = stop_end;
            else if (stop_end && i >= stop_from) cu.Stop = 1'b1;
            else                                 cu.Stop = 1'($urandom_range(1, 0));
            cyc(seq_q[i], $sformatf("op%b_step%0d", ir[31:27], i));
        end
        if (stop_end) begin
            for (int unsigned k = 0; k < park; k++) cyc(32'd0, "park_hold");
            cu.Stop = 1'b0;
            cyc(32'd0, "park_exit");
        end
    endtask

    initial begin
        logic [4:0] op;
        Reset   = 1'b1;
        cu.Stop = 1'b0;
        cu.CON  = 1'b0;
        cu.IR   = '0;
        @(posedge Clock);
        #1;
        cyc(32'd0, "reset_c0");
        cyc(32'd0, "reset_c1");
        Reset = 1'b0;
        cyc(32'd0, "rst_state");

        // ori R2,R3,0x25
        run_instr(32'h7118_0025, 1'b0, 1'b0, 0, 0);
        run_instr({5'b00000, 27'($urandom)}, 1'b0, 1'b0, 0, 0);
        run_instr({5'b00000, 27'($urandom)}, 1'b1, 1'b0, 0, 0);
        run_instr({5'b10011, 27'($urandom)}, 1'b0, 1'b0, 0, 0);
        run_instr({5'b10011, 27'($urandom)}, 1'b1, 1'b0, 0, 0);
        // add with Stop raised from T4 onward: completes, then parks
        run_instr({5'b00011, 27'($urandom)}, 1'b0, 1'b1, 4, 2);
        run_instr({5'b11010, 27'($urandom)}, 1'b0, 1'b0, 0, 0);

        // halt: fetch, then absorbing until Reset
        cu.Stop = 1'b0;
        build(5'b11011, 1'b0);
        cu.IR = {5'b11011, 27'($urandom)};
        for (int unsigned i = 0; i < 3; i++) cyc(seq_q[i], $sformatf("halt_fetch%0d", i));
        for (int unsigned i = 0; i < 20; i++) begin
            cu.Stop = 1'($urandom_range(1, 0));
            cu.CON  = 1'($urandom_range(1, 0));
            cyc(32'd0, $sformatf("halt_idle%0d", i));
        end
        cu.Stop = 1'b0;
        Reset   = 1'b1;
        cyc(32'd0, "halt_reset");
        Reset = 1'b0;
        cyc(32'd0, "halt_rst_state");
        run_instr({5'b10110, 27'($urandom)}, 1'b0, 1'b0, 0, 0);

        // st aborted by Reset in T6; release with Stop high goes to PARK
        cu.Stop = 1'b0;
        build(5'b00010, 1'b0);
        cu.IR = {5'b00010, 27'($urandom)};
        for (int unsigned i = 0; i < 6; i++) cyc(seq_q[i], $sformatf("st_abort_step%0d", i));
        Reset = 1'b1;
        cyc(32'd0, "st_reset_T6");
        cyc(32'd0, "st_reset_hold");
        Reset   = 1'b0;
        cu.Stop = 1'b1;
        cyc(32'd0, "rst_to_park");
        cyc(32'd0, "park_after_rst");
        cu.Stop = 1'b0;
        cyc(32'd0, "park_release");

        for (int unsigned t = 0; t < 200; t++) begin
            op = 5'($urandom_range(31, 0));
            if (op == 5'b11011) op = 5'b11010;
            run_instr({op, 27'($urandom)}, 1'($urandom_range(1, 0)),
                      ($urandom_range(3, 0) == 0), $urandom_range(7, 0), $urandom_range(3, 0));
        end

        @(negedge Clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore control unit that sequences the single-bus CPU datapath. Each clock cycle is one control step. It drives every register-in and bus-out strobe, the register-select lines (Gra/Grb/Grc/Rin/Rout/BAout) and the memory strobes (Read/write) from its state and the instruction register. It replaces bench-driven control and sits beside `datapath`, with its outputs wired one-to-one to the datapath control inputs.

## Interface
- No parameters; opcode encodings are fixed in the shared package.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- IR  in  32  instruction register contents; opcode is IR[31:27].
- CON  in  1  branch-condition flip-flop output from the datapath.
- Stop  in  1  when high, park before the next fetch.
- HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  out  1 each  register load enables.
- HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout  out  1 each  bus drive enables. OUTPORTout is tied 0.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select and control.
- Read, write, IncPC  out  1 each  memory read, memory write, PC increment.
- Run  out  1  high while executing; low in RST, PARK and HALT.

## Operation
States are RST, PARK, T0–T7 and HALT. Outputs decode from the registered state plus the IR opcode. At most one bus-out strobe is high per step.

- **Fetch (all instructions)**
  - T0: PCout, MARin.
  - T1: Read, MDRin, PCin, IncPC.
  - T2: MDRout, IRin.
- **add/sub/and/or/ror/rol/shr/shra/shl**
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin.
  - T5: ZLOout, Gra, Rin.
- **addi/andi/ori**: same as above, except T4 is Cout, Zin.
- **ldi**
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin.
  - T5: ZLOout, Gra, Rin.
- **ld**: T3–T4 as ldi, then:
  - T5: ZLOout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- **st**: T3–T5 as ld, then:
  - T6: Gra, Rout, MDRin.
  - T7: write.
- **neg/not**
  - T3: Grb, Rout, Zin.
  - T4: ZLOout, Gra, Rin.
- **mul/div**
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin.
  - T5: ZLOout, LOin.
  - T6: ZHIout, HIin.
- **br**
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin.
  - T6: ZLOout, PCin only if CON=1; otherwise no strobes.
- **Single-step (T3 only)**
  - jr: Gra, Rout, PCin.
  - in: INPORTout, Gra, Rin.
  - out: Gra, Rout, OUTPORTin.
  - mfhi: HIout, Gra, Rin.
  - mflo: LOout, Gra, Rin.
- **nop and unassigned opcodes 11100–11111**: return to T0 after T2.
- **halt**: enter HALT after T2. HALT is left only by Reset.
- **ALU function**: the datapath decodes it from IR. ld/ldi/st use add. The control unit issues no ALU select.

## Timing
- **Step length**: one cycle per step. Strobes are high for the whole cycle. Destination registers capture on the rising edge that ends the step.
- **Reset**
  - Every output is 0 during Reset and in RST.
  - RST moves to T0 (or PARK if Stop=1) on the first edge with Reset low.
  - Reset mid-instruction aborts it. All strobes are 0 from the next cycle. No partial write follows.
- **Latency**, fetch included:
  - 3 cycles: nop.
  - 4 cycles: jr, in, out, mfhi, mflo.
  - 5 cycles: neg, not.
  - 6 cycles: ALU, immediate, ldi.
  - 7 cycles: mul, div, br.
  - 8 cycles: ld, st.
- **Stop**: sampled only on the last step of an instruction or in PARK.
  - Stop=1 there → PARK.
  - Stop=0 in PARK → T0 next cycle.
  - Stop never interrupts an instruction mid-flight.
- **CON**: sampled combinationally in T6 of br. It is stable because CONin was loaded at T3.
- **HALT**: absorbing. Run=0 and all strobes 0.

## Configuration
- `CU_MULDIV_EN` defined: mul/div run the 7-cycle sequence above.
- Not defined: mul/div opcodes are treated as nop (3 cycles). HIin, LOin and ZHIout stay 0 for the whole run.

## Structure
- `cpu_pkg` holds:
  - `opcode_t` localparams: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011.
  - `cu_state_t` state encoding.
- Sub-module `cu_step_decode`: purely combinational (state, opcode, CON) → strobe vector. `control_unit` keeps the state register and next-state logic.

## Test plan
- Reset high 2 cycles, then low, Stop=0, IR=32'h7118_0025 (ori R2,R3,0x25) → Run=1. T3 shows Grb+Rout+Yin, T4 Cout+Zin, T5 ZLOout+Gra+Rin. T0 recurs 6 cycles after the first T0.
- IR=ld (opcode 00000) → exactly 8 cycles per instruction. Read is high in T1 and T6 only; MARin in T0 and T5; Gra+Rin in T7.
- IR=br: with CON=0, PCin is high only in T1. With CON=1, PCin is high in T1 and T6.
- IR=halt → Run falls after T2 and stays 0 with all strobes 0 for 20 cycles. Reset pulse → T0 resumes.
- st with Reset asserted during T6 → write is never high. All outputs are 0 the cycle after the Reset edge.
- Stop raised during T4 of add → the instruction completes through T5, then PARK with Run=0. Stop dropped → T0 on the next cycle.
